// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin sharing of one stb/ack fpu_adder among NREQ requesters.
// Define FPU_ARB_TIMEOUT_EN to add the DELIVER timeout and its timeout_err pulse.
module fpu_add_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_stb,
  output logic [NREQ-1:0]    req_ack,
  output logic [31:0]        resp_z,
  output logic [NREQ-1:0]    resp_stb,
  input  logic [NREQ-1:0]    resp_ack,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  output logic               fpu_input_stb,
  input  logic               fpu_input_ack,
  input  logic [31:0]        fpu_z,
  input  logic               fpu_output_stb,
  output logic               fpu_output_ack,
  output logic               busy,
  output logic [IDW-1:0]     grant_id
`ifdef FPU_ARB_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  state_t state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n, grant_n, win, nxt;
  logic [31:0] a_n, b_n, z_n;
  logic [NREQ-1:0] req_ack_n, resp_stb_n;
  logic in_stb_n, out_ack_n, expired;
  if (NREQ < 2 || NREQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("fpu_add_arbiter: parameter out of range");
  end
  assign nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_stb[IDW'((int'(rr_ptr) + k) % NREQ)]) win = IDW'((int'(rr_ptr) + k) % NREQ);
  end
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state == DELIVER) ? cnt + 1'b1 : '0;
      timeout_err <= state == DELIVER && !resp_ack[grant_id] && expired;
    end
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    grant_n = grant_id;
    a_n = fpu_a;
    b_n = fpu_b;
    z_n = resp_z;
    resp_stb_n = resp_stb;
    req_ack_n = '0;
    in_stb_n = 1'b0;
    out_ack_n = 1'b0;
    case (state)
      IDLE: if (|req_stb) begin
        state_n = ISSUE;
        grant_n = win;
        a_n = req_a[32*win +: 32];
        b_n = req_b[32*win +: 32];
        req_ack_n = NREQ'(1) << win;
      end
      ISSUE: if (fpu_input_ack) begin
        state_n = WAIT;
        in_stb_n = 1'b1;
      end
      WAIT: if (fpu_output_stb) begin
        state_n = DELIVER;
        z_n = fpu_z;
        out_ack_n = 1'b1;
        resp_stb_n = NREQ'(1) << grant_id;
      end
      DELIVER: if (resp_ack[grant_id] || expired) begin
        state_n = IDLE;
        resp_stb_n = '0;
        rr_ptr_n = nxt;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      fpu_a <= '0;
      fpu_b <= '0;
      resp_z <= '0;
      resp_stb <= '0;
      req_ack <= '0;
      fpu_input_stb <= 1'b0;
      fpu_output_ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      grant_id <= grant_n;
      fpu_a <= a_n;
      fpu_b <= b_n;
      resp_z <= z_n;
      resp_stb <= resp_stb_n;
      req_ack <= req_ack_n;
      fpu_input_stb <= in_stb_n;
      fpu_output_ack <= out_ack_n;
      busy <= state_n != IDLE;
    end
endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter: table vectors plus hand sequences against a behavioural adder stub,
// with a scoreboard filled on req_ack and drained on each new resp_stb.
module tb_fpu_add_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0, rst;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0] req_stb, req_ack, resp_stb, resp_ack;
  logic [31:0] resp_z, fpu_a, fpu_b, fpu_z;
  logic fpu_input_stb, fpu_input_ack, fpu_output_stb, fpu_output_ack, busy;
  logic [1:0] grant_id;
`ifdef FPU_ARB_TIMEOUT_EN
  logic timeout_err;
`endif
  fpu_add_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_input_stb(fpu_input_stb), .fpu_input_ack(fpu_input_ack), .fpu_z(fpu_z),
    .fpu_output_stb(fpu_output_stb), .fpu_output_ack(fpu_output_ack), .busy(busy),
    .grant_id(grant_id)
`ifdef FPU_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { int id; logic [31:0] a, b, z; } vec_t;
  typedef struct { int id; logic [31:0] z; } sb_t;
  vec_t vec[6];
  sb_t sbq[$];
  sb_t e_mon;
  int grants[$];
  int checks = 0, fails = 0, lat, stray;
  logic ack_block, s_busy, s_ready;
  int s_cnt;
  logic [31:0] s_z, z_got;
  logic [NREQ-1:0] prev_ack, prev_resp;
  logic prev_iack, prev_istb, prev_ostb;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // Adder result for known IEEE vectors; any other pair gets an arbitrary but deterministic value.
  function automatic logic [31:0] fz(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 6; i++) if (vec[i].a == a && vec[i].b == b) return vec[i].z;
    return a + b;
  endfunction
  // Non-pipelined adder stub: captures on input_stb alone, answers after lat cycles.
  assign fpu_input_ack = s_ready & ~ack_block;
  always @(posedge clk) begin
    if (!rst) begin
      s_busy <= 1'b0; s_ready <= 1'b1; fpu_output_stb <= 1'b0; fpu_z <= '0; s_cnt <= 0;
    end else if (!s_busy) begin
      if (fpu_input_stb) begin
        s_busy <= 1'b1; s_ready <= 1'b0; s_cnt <= lat; s_z <= fz(fpu_a, fpu_b);
      end
    end else if (!fpu_output_stb) begin
      if (s_cnt <= 1) begin fpu_output_stb <= 1'b1; fpu_z <= s_z; end
      else s_cnt <= s_cnt - 1;
    end else if (fpu_output_ack) begin
      fpu_output_stb <= 1'b0; s_busy <= 1'b0; s_ready <= 1'b1;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      if (req_ack != 0) begin
        chk("req_ack_onehot", 32'($onehot(req_ack)), 1);
        chk("req_ack_pulse", 32'(prev_ack), 0);
        for (int i = 0; i < NREQ; i++) if (req_ack[i]) begin
          grants.push_back(i);
          chk("fpu_a_capture", fpu_a, req_a[32*i +: 32]);
          chk("fpu_b_capture", fpu_b, req_b[32*i +: 32]);
          sbq.push_back('{i, fz(req_a[32*i +: 32], req_b[32*i +: 32])});
        end
      end
      if (resp_stb != 0 && prev_resp == 0) begin
        if (sbq.size() == 0) chk("resp_unexpected", 32'(resp_stb), 0);
        else begin
          e_mon = sbq.pop_front();
          chk("sb_resp_stb", 32'(resp_stb), 32'(1) << e_mon.id);
          chk("sb_resp_z", resp_z, e_mon.z);
          chk("sb_grant_id", 32'(grant_id), e_mon.id);
        end
      end
      if (fpu_input_stb) begin
        chk("input_stb_after_ack", 32'(prev_iack), 1);
        chk("input_stb_one_cycle", 32'(prev_istb), 0);
      end
      if (fpu_output_ack) chk("output_ack_after_stb", 32'(prev_ostb), 1);
    end
    prev_ack = req_ack; prev_resp = resp_stb;
    prev_iack = fpu_input_ack; prev_istb = fpu_input_stb; prev_ostb = fpu_output_stb;
  end
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, output logic [31:0] z);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_stb[id] = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 60 && !req_ack[id]; n++) @(negedge clk);
    chk("req_ack_seen", 32'(req_ack[id]), 1);
    @(posedge clk); #1 req_stb[id] = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 100 && !resp_stb[id]; n++) @(negedge clk);
    chk("resp_stb_seen", 32'(resp_stb[id]), 1);
    z = resp_z;
  endtask
  task automatic wait_idle();
    @(negedge clk);
    for (int n = 0; n < 200 && (busy || sbq.size() != 0); n++) @(negedge clk);
    chk("idle_reached", 32'(busy), 0);
    chk("scoreboard_drained", sbq.size(), 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000};
    vec[1] = '{2, 32'h7F800000, 32'hFF800000, 32'hFFC00000};
    vec[2] = '{3, 32'h3F800000, 32'hBF800000, 32'h00000000};
    vec[3] = '{1, 32'h80000000, 32'h80000000, 32'h80000000};
    vec[4] = '{3, 32'h7FC00123, 32'h3F800000, 32'h7FC00123};
    vec[5] = '{0, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    rst = 1'b0; req_stb = '1; resp_ack = '1; ack_block = 1'b0; lat = 3;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'(i + 1) << 24;
      req_b[32*i +: 32] = 32'(i + 5);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_resp_stb", 32'(resp_stb), 0);
    chk("rst_input_stb", 32'(fpu_input_stb), 0);
    chk("rst_output_ack", 32'(fpu_output_ack), 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    // All requesters held high from reset release: rotation 0,1,2,3,0.
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 400 && grants.size() < 5; n++) @(negedge clk);
    chk("grant_count", 32'(grants.size() >= 5), 1);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("grant_order", grants[i], i % NREQ);
    @(posedge clk); #1 req_stb = '0;
    wait_idle();
    foreach (vec[i]) begin
      run_op(vec[i].id, vec[i].a, vec[i].b, z_got);
      chk("vec_resp_z", z_got, vec[i].z);
      wait_idle();
    end
    // Result held in DELIVER while the winner withholds resp_ack; other ack bits ignored.
    resp_ack = 4'b1101;
    run_op(1, 32'h3F800000, 32'h40000000, z_got);
    req_a[64 +: 32] = 32'h40400000; req_b[64 +: 32] = 32'h40400000; req_stb[2] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("hold_resp_stb", 32'(resp_stb), 32'h2);
      chk("hold_resp_z", resp_z, 32'h40400000);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_no_req_ack", 32'(req_ack), 0);
    end
    resp_ack = '1;
    run_op(2, 32'h40400000, 32'h40400000, z_got);
    wait_idle();
    // Adder not ready: input_stb must stay low until input_ack returns.
    ack_block = 1'b1;
    req_a[32 +: 32] = 32'h40A00000; req_b[32 +: 32] = 32'h40A00000; req_stb[1] = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 60 && !req_ack[1]; n++) @(negedge clk);
    chk("blk_req_ack", 32'(req_ack[1]), 1);
    @(posedge clk); #1 req_stb[1] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("blk_no_input_stb", 32'(fpu_input_stb), 0);
      chk("blk_busy", 32'(busy), 1);
    end
    ack_block = 1'b0;
    for (int n = 0; n < 100 && !resp_stb[1]; n++) @(negedge clk);
    chk("blk_resp_z", resp_z, 32'h81400000);
    wait_idle();
    // Reset pulse while the op sits in WAIT.
    lat = 8;
    req_a[64 +: 32] = 32'h41200000; req_b[64 +: 32] = 32'h3F800000; req_stb[2] = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 60 && !req_ack[2]; n++) @(negedge clk);
    chk("mid_req_ack", 32'(req_ack[2]), 1);
    @(posedge clk); #1 req_stb[2] = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 20 && !fpu_input_stb; n++) @(negedge clk);
    chk("mid_input_stb", 32'(fpu_input_stb), 1);
    @(posedge clk); #1 rst = 1'b0; sbq.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_req_ack0", 32'(req_ack), 0);
    chk("mid_resp_stb0", 32'(resp_stb), 0);
    chk("mid_input_stb0", 32'(fpu_input_stb), 0);
    chk("mid_output_ack0", 32'(fpu_output_ack), 0);
    chk("mid_resp_z0", resp_z, 0);
    chk("mid_busy0", 32'(busy), 0);
    chk("mid_grant_id0", 32'(grant_id), 0);
    stray = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (resp_stb != 0) stray++;
    end
    chk("mid_no_resp", stray, 0);
    lat = 3;
    run_op(0, 32'h3F800000, 32'h40000000, z_got);
    chk("post_rst_resp_z", z_got, 32'h40400000);
    wait_idle();
`ifdef FPU_ARB_TIMEOUT_EN
    begin
      int d;
      resp_ack = '0;
      run_op(1, 32'h3F800000, 32'hBF800000, z_got);
      d = 1;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (!resp_stb[1]) break;
        d++;
      end
      chk("tmo_deliver_cycles", d, 8);
      chk("tmo_err_pulse", 32'(timeout_err), 1);
      chk("tmo_idle", 32'(busy), 0);
      resp_ack = '1;
      req_stb[1] = 1'b1; req_stb[2] = 1'b1;
      @(negedge clk);
      chk("tmo_err_clear", 32'(timeout_err), 0);
      chk("tmo_rr_advanced", 32'(req_ack), 32'h4);
      @(posedge clk); #1 req_stb[2] = 1'b0;
      for (int n = 0; n < 100 && !req_ack[1]; n++) @(negedge clk);
      chk("tmo_next_req_ack", 32'(req_ack[1]), 1);
      @(posedge clk); #1 req_stb[1] = 1'b0;
      wait_idle();
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
